// File: rtl/bcd_display_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// request/busy/done handshake; saturates to all nines when the value does not fit.
module bcd_display_converter #(
    parameter int IN_W = 32,
    parameter int NDIG = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [IN_W-1:0]   bin_in,
    input  logic              bin_valid,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] bcd_out,
    output logic              ovf
);

    localparam int CW = $clog2(IN_W + 1);
    localparam int BW = 4 * NDIG;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IN_W-1:0] shift_reg;
    logic [BW-1:0]   scratch;
    logic            ovf_scratch;
    logic [CW-1:0]   cnt;

    logic [BW-1:0]   adj;
    logic [BW-1:0]   scratch_shifted;
    logic            carry_out;
    logic            last_shift;

    always_comb begin
        adj = scratch;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        scratch_shifted = {adj[BW-2:0], shift_reg[IN_W-1]};
        carry_out       = adj[BW-1];
        last_shift      = (cnt == CW'(IN_W - 1));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bin_valid) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shift_reg   <= '0;
            scratch     <= '0;
            ovf_scratch <= 1'b0;
            cnt         <= '0;
            bcd_out     <= '0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bin_valid) begin
                        shift_reg   <= bin_in;
                        scratch     <= '0;
                        ovf_scratch <= 1'b0;
                        cnt         <= '0;
                    end
                end
                SHIFT: begin
                    shift_reg   <= {shift_reg[IN_W-2:0], 1'b0};
                    scratch     <= scratch_shifted;
                    ovf_scratch <= ovf_scratch | carry_out;
                    cnt         <= cnt + 1'b1;
                    // Final shift's carry must be folded in directly, not via ovf_scratch.
                    if (last_shift) begin
                        if (ovf_scratch | carry_out) begin
                            bcd_out <= {NDIG{4'd9}};
                            ovf     <= 1'b1;
                        end else begin
                            bcd_out <= scratch_shifted;
                            ovf     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_display_converter.sv
// Directed self-checking bench for bcd_display_converter (IN_W=32, NDIG=2).
module tb_bcd_display_converter;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] bin_in = '0;
    logic        bin_valid = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  bcd_out;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    bcd_display_converter #(.IN_W(32), .NDIG(2)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bin_in   (bin_in),
        .bin_valid(bin_valid),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .ovf      (ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a one-cycle request; returns #1 after the acceptance edge.
    task automatic start(input logic [31:0] v);
        bin_in    = v;
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
    endtask

    // Steps until done is seen (bounded); reports edges taken and busy samples.
    task automatic wait_done(output int n, output int busy_cnt);
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 60) begin
            if (busy) busy_cnt++;
            step();
            n++;
        end
        if (busy) busy_cnt++;
    endtask

    task automatic conv(input string tag, input logic [31:0] v,
                        input logic [7:0] exp_bcd, input logic exp_ovf);
        int n, bc;
        start(v);
        wait_done(n, bc);
        check({tag, "_lat"}, n, 32);
        check({tag, "_bcd"}, bcd_out, exp_bcd);
        check({tag, "_ovf"}, ovf, exp_ovf);
        step();
        check({tag, "_idle"}, {done, busy}, 2'b00);
    endtask

    initial begin
        int n, bc, hits;

        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd_out, 8'h00);
        check("rst_ovf", ovf, 1'b0);
        resetn = 1'b1;
        step();

        // Test 1: 47, full timing
        start(32'd47);
        check("t1_busy_e0", busy, 1'b1);
        wait_done(n, bc);
        check("t1_lat", n, 32);
        check("t1_busy_cycles", bc, 33);
        check("t1_bcd", bcd_out, 8'h47);
        check("t1_ovf", ovf, 1'b0);
        step();
        check("t1_done_pulse", done, 1'b0);
        check("t1_busy_low", busy, 1'b0);
        repeat (5) step();
        check("t1_hold", bcd_out, 8'h47);

        // Test 2: boundaries
        conv("t2_0", 32'd0, 8'h00, 1'b0);
        conv("t2_9", 32'd9, 8'h09, 1'b0);
        conv("t2_10", 32'd10, 8'h10, 1'b0);
        conv("t2_99", 32'd99, 8'h99, 1'b0);

        // Test 3: overflow and recovery
        conv("t3_100", 32'd100, 8'h99, 1'b1);
        conv("t3_max", 32'hFFFF_FFFF, 8'h99, 1'b1);
        conv("t3_5", 32'd5, 8'h05, 1'b0);

        // Test 4: request while busy is ignored
        start(32'd12);
        repeat (9) step();
        bin_in    = 32'd34;
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        wait_done(n, bc);
        check("t4_lat", n, 22);
        check("t4_bcd", bcd_out, 8'h12);
        hits = 0;
        repeat (40) begin
            step();
            if (done || busy) hits++;
        end
        check("t4_no_second", hits, 0);
        check("t4_hold", bcd_out, 8'h12);

        // Test 5: level-held request
        bin_in    = 32'd56;
        bin_valid = 1'b1;
        step();
        wait_done(n, bc);
        check("t5_lat", n, 32);
        check("t5_bcd0", bcd_out, 8'h56);
        for (int k = 0; k < 2; k++) begin
            step();
            wait_done(n, bc);
            check("t5_period", n + 1, 34);
            check("t5_bcd", bcd_out, 8'h56);
        end
        bin_valid = 1'b0;
        step();
        check("t5_idle", busy, 1'b0);

        // Test 6: reset mid-conversion
        start(32'd73);
        repeat (14) step();
        check("t6_busy_pre", busy, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_bcd", bcd_out, 8'h00);
        check("t6_ovf", ovf, 1'b0);
        step();
        resetn = 1'b1;
        hits = 0;
        repeat (40) begin
            step();
            if (done || busy) hits++;
        end
        check("t6_quiet", hits, 0);
        check("t6_bcd_hold", bcd_out, 8'h00);
        conv("t6_after", 32'd73, 8'h73, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
